bf16_div: RTL and testbench
===========================

Name: bf16_div

Overview:
- Iterative BFloat16 divider, a = dividend, b = divisor. Subtraction inverts addition but is only a sign flip on the existing adder, so the team takes the arithmetic inverse of the multiply path instead.
- One quotient bit per cycle (restoring division). Valid/ready handshake on both input and output sides.
- Sits beside bf16_add in the arithmetic unit and uses the same split sign/exponent/mantissa operand format.

Parameters:
- ITER, 10, quotient bits generated: 1 integer + 7 fraction + guard + round. Fixed for bf16; exposed only for bench sweeps.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  operands valid
- ready_o  out  1  divider can accept operands (high only in IDLE)
- sa_i  in  1  dividend sign
- ea_i  in  8  dividend biased exponent
- ma_i  in  7  dividend mantissa, hidden bit implicit
- sb_i  in  1  divisor sign
- eb_i  in  8  divisor biased exponent
- mb_i  in  7  divisor mantissa
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- s_o  out  1  result sign
- e_o  out  8  result exponent
- m_o  out  7  result mantissa

Behaviour:
- Reset values: ready_o=1, valid_o=0, s_o=0, e_o=0, m_o=0. FSM returns to IDLE; any in-flight operation is discarded, with no output and no partial result.
- FSM states and transitions:
  - IDLE: accept when valid_i & ready_o. A special case goes to DONE; otherwise go to DIV.
  - DIV: runs exactly ITER cycles under a 4-bit iteration counter, then goes to ROUND.
  - ROUND: takes 1 cycle, then goes to DONE.
  - DONE: valid_o=1 and outputs held stable. Leave for IDLE on valid_o & ready_i. No new accept while in DONE.
- Latency, counted from the accepting edge to the first cycle of valid_o:
  - normal operands: ITER+2 = 12 cycles
  - special cases: 1 cycle
- Throughput: one operation in flight; ready_o=0 from the accept edge until the DONE handshake completes.
- Sign: s_o = sa_i ^ sb_i for every result except NaN (NaN sign=0).
- Denormals: flushed to zero on input (e=0 means zero); results that underflow flush to zero.
- Special cases, in priority order:
  1. a NaN, b NaN, 0/0, or inf/inf -> canonical NaN: e=8'hFF, m=7'h40.
  2. a inf or b zero -> signed inf: e=8'hFF, m=0.
  3. a zero or b inf -> signed zero.
- Datapath:
  - Operands are 8-bit significands {1,m}.
  - If ma < mb, shift the dividend left by 1 and set adj=1.
  - Exponent: signed 10-bit value e = ea - eb + 127 - adj.
  - Restoring step, per cycle: rem >= div ? (rem -= div, q bit 1) : q bit 0; then rem <<= 1.
  - Quotient q[9:0] lies in [1,2).
- Round to nearest even in ROUND:
  - lsb = q[2], G = q[1], R = q[0], S = (rem != 0).
  - Increment when G & (R | S | lsb).
  - If the mantissa increment carries out (1.1111111 -> 10.0), set m=0 and e += 1.
- Range after rounding:
  - e >= 255 -> signed inf
  - e <= 0 -> signed zero
- valid_i while busy is ignored; the operand is neither captured nor dropped, and the source must hold it.
- ready_i low in DONE: valid_o and the outputs stay stable indefinitely.

Decomposition:
- Shared package bf16_pkg, containing:
  - bf16_t struct: s, e[7:0], m[6:0]
  - constants BIAS=127, EXP_MAX=8'hFF, QNAN_M=7'h40
  - helper functions is_zero, is_inf, is_nan
- This package is to be reused by bf16_add and the benches.
- One natural sub-module, bf16_div_round: combinational RNE rounding plus final range check. Inputs are q, sticky, signed exponent and sign; outputs are the packed result.

Test Plan:
- 0x3F80 / 0x3F80 (1.0/1.0) -> 0x3F80; valid_o exactly 12 cycles after accept; ready_o low throughout.
- 0x3F80 / 0x4040 (1/3) -> 0x3EAB. This exercises adj=1 and round-up with G=1, S=1.
- 0xC0C0 / 0x4000 (-6/2) -> 0xC040. Then 0x3F80 / 0x0000 -> 0x7F80 and 0x0000 / 0x0000 -> 0x7FC0, each with a 1-cycle latency.
- 0x7F00 / 0x3E80 (2^127 / 0.25) -> 0x7F80 (overflow). 0x0080 / 0x7F00 -> 0x0000 (underflow flush).
- Backpressure: hold ready_i=0 for 20 cycles in DONE -> outputs and valid_o stable, ready_o=0, and a new valid_i is not accepted. Releasing ready_i returns the FSM to IDLE next cycle.
- Assert rst in cycle 5 of DIV -> valid_o=0 and ready_o=1 immediately. The next operation, 1/3, completes correctly with 0x3EAB.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared BFloat16 operand format, constants and classification helpers.
// Used by the divider, the adder and the benches.
package bf16_pkg;

    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] m;
    } bf16_t;

    localparam int         BIAS    = 127;
    localparam logic [7:0] EXP_MAX = 8'hFF;
    localparam logic [6:0] QNAN_M  = 7'h40;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_ROUND,
        S_DONE
    } div_state_e;

    // Denormals are flushed, so a zero exponent alone means zero.
    function automatic logic is_zero(input bf16_t x);
        return x.e == 8'h00;
    endfunction

    function automatic logic is_inf(input bf16_t x);
        return (x.e == EXP_MAX) && (x.m == 7'h00);
    endfunction

    function automatic logic is_nan(input bf16_t x);
        return (x.e == EXP_MAX) && (x.m != 7'h00);
    endfunction

endpackage

// File: rtl/bf16_div_round.sv
// Round-to-nearest-even of the raw quotient plus final overflow/underflow
// clamping into a packed bf16 result.
module bf16_div_round
    import bf16_pkg::*;
#(
    parameter int ITER = 10
) (
    input  logic [ITER-1:0]   q_i,
    input  logic              sticky_i,
    input  logic signed [9:0] exp_i,
    input  logic              sign_i,
    output bf16_t             res_o
);

    logic              low_sticky;
    logic              lsb;
    logic              guard;
    logic              rnd;
    logic              sticky;
    logic              round_up;
    logic [8:0]        sig_inc;
    logic [6:0]        frac;
    logic signed [9:0] exp_adj;

    // Quotient bits below the round bit only exist when ITER is widened.
    generate
        if (ITER > 10) begin : g_low
            assign low_sticky = |q_i[ITER-11:0];
        end else begin : g_no_low
            assign low_sticky = 1'b0;
        end
    endgenerate

    always_comb begin
        lsb      = q_i[ITER-8];
        guard    = q_i[ITER-9];
        rnd      = q_i[ITER-10];
        sticky   = sticky_i | low_sticky;
        round_up = guard & (rnd | sticky | lsb);
        sig_inc  = {1'b0, q_i[ITER-1 -: 8]} + {8'h00, round_up};

        // A carry out of 1.1111111 renormalises to 1.0000000 one binade up.
        if (sig_inc[8]) begin
            frac    = sig_inc[7:1];
            exp_adj = exp_i + 10'sd1;
        end else begin
            frac    = sig_inc[6:0];
            exp_adj = exp_i;
        end

        if (exp_adj >= 10'sd255) begin
            res_o = {sign_i, EXP_MAX, 7'h00};
        end else if (exp_adj <= 10'sd0) begin
            res_o = {sign_i, 8'h00, 7'h00};
        end else begin
            res_o = {sign_i, exp_adj[7:0], frac};
        end
    end

endmodule

// File: rtl/bf16_div.sv
// Iterative bf16 divider: restoring division, one quotient bit per cycle,
// valid/ready on both sides, one operation in flight.
module bf16_div
    import bf16_pkg::*;
#(
    parameter int ITER = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       sa_i,
    input  logic [7:0] ea_i,
    input  logic [6:0] ma_i,
    input  logic       sb_i,
    input  logic [7:0] eb_i,
    input  logic [6:0] mb_i,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       s_o,
    output logic [7:0] e_o,
    output logic [6:0] m_o
);

    div_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [9:0]        rem_q, rem_d;
    logic [7:0]        div_q, div_d;
    logic [ITER-1:0]   q_q, q_d;
    logic signed [9:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    bf16_t             res_q, res_d;

    bf16_t             a_in;
    bf16_t             b_in;
    bf16_t             rnd_res;
    logic              sign_in;
    logic              adj;
    logic              is_qnan;
    logic              is_inf_res;
    logic              is_zero_res;
    logic [9:0]        rem_diff;
    logic              q_bit;
    logic signed [9:0] exp_in;

    assign a_in = {sa_i, ea_i, ma_i};
    assign b_in = {sb_i, eb_i, mb_i};

    always_comb begin
        sign_in     = sa_i ^ sb_i;
        is_qnan     = is_nan(a_in) | is_nan(b_in)
                    | (is_zero(a_in) & is_zero(b_in))
                    | (is_inf(a_in) & is_inf(b_in));
        is_inf_res  = is_inf(a_in) | is_zero(b_in);
        is_zero_res = is_zero(a_in) | is_inf(b_in);
        // Pre-shifting the smaller dividend keeps the quotient in [1,2).
        adj         = ma_i < mb_i;
        exp_in      = $signed({2'b00, ea_i}) - $signed({2'b00, eb_i})
                    + 10'(BIAS) - $signed({9'b0, adj});
    end

    always_comb begin
        if (rem_q >= {2'b00, div_q}) begin
            rem_diff = rem_q - {2'b00, div_q};
            q_bit    = 1'b1;
        end else begin
            rem_diff = rem_q;
            q_bit    = 1'b0;
        end
    end

    bf16_div_round #(
        .ITER(ITER)
    ) u_round (
        .q_i     (q_q),
        .sticky_i(|rem_q),
        .exp_i   (exp_q),
        .sign_i  (sign_q),
        .res_o   (rnd_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    sign_d = sign_in;
                    if (is_qnan) begin
                        res_d   = {1'b0, EXP_MAX, QNAN_M};
                        state_d = S_DONE;
                    end else if (is_inf_res) begin
                        res_d   = {sign_in, EXP_MAX, 7'h00};
                        state_d = S_DONE;
                    end else if (is_zero_res) begin
                        res_d   = {sign_in, 8'h00, 7'h00};
                        state_d = S_DONE;
                    end else begin
                        div_d   = {1'b1, mb_i};
                        rem_d   = adj ? {1'b0, 1'b1, ma_i, 1'b0} : {2'b00, 1'b1, ma_i};
                        exp_d   = exp_in;
                        q_d     = '0;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                rem_d = rem_diff << 1;
                q_d   = {q_q[ITER-2:0], q_bit};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(ITER - 1)) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                res_d   = rnd_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_q     <= q_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign s_o     = res_q.s;
    assign e_o     = res_q.e;
    assign m_o     = res_q.m;

endmodule

// File: tb/tb_bf16_div.sv
// Randomised bench for bf16_div against an exact-rational division model,
// with fixed directed cases for specials, range limits, backpressure and reset.
module tb_bf16_div;

    localparam int ITER = 10;

    logic       clk;
    logic       rst;
    logic       valid_i;
    logic       ready_o;
    logic       sa_i;
    logic [7:0] ea_i;
    logic [6:0] ma_i;
    logic       sb_i;
    logic [7:0] eb_i;
    logic [6:0] mb_i;
    logic       valid_o;
    logic       ready_i;
    logic       s_o;
    logic [7:0] e_o;
    logic [6:0] m_o;

    logic [16:0] lit_exp;
    int          n_cmp = 0;
    int          n_bad = 0;

    bf16_div #(.ITER(ITER)) dut (
        .clk    (clk),
        .rst    (rst),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .sa_i   (sa_i),
        .ea_i   (ea_i),
        .ma_i   (ma_i),
        .sb_i   (sb_i),
        .eb_i   (eb_i),
        .mb_i   (mb_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .s_o    (s_o),
        .e_o    (e_o),
        .m_o    (m_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {special, result}: the exact quotient scaled by 2^20 is rounded
    // to nearest-even using the true remainder as the tie breaker.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        logic   s;
        logic   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint num, den, quo, rem, mant, tail, half;
        int     e, k;
        s      = a[15] ^ b[15];
        a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 0);
        b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 0);
        a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 0);
        b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 0);
        a_zero = (a[14:7] == 8'h00);
        b_zero = (b[14:7] == 8'h00);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {1'b1, 16'h7FC0};
        if (a_inf || b_zero) return {1'b1, s, 8'hFF, 7'h00};
        if (a_zero || b_inf) return {1'b1, s, 15'h0000};
        num = longint'(128 + int'(a[6:0])) << 20;
        den = longint'(128 + int'(b[6:0]));
        quo = num / den;
        rem = num % den;
        if (quo >= (longint'(1) << 20)) begin
            e = int'(a[14:7]) - int'(b[14:7]) + 127;
            k = 13;
        end else begin
            e = int'(a[14:7]) - int'(b[14:7]) + 126;
            k = 12;
        end
        mant = quo >> k;
        tail = quo & ((longint'(1) << k) - 1);
        half = longint'(1) << (k - 1);
        if (tail > half || (tail == half && (rem != 0 || (mant & 1) != 0))) mant = mant + 1;
        if (mant == 256) begin
            mant = 128;
            e    = e + 1;
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 7'h00};
        if (e <= 0) return {1'b0, s, 15'h0000};
        return {1'b0, s, 8'(e), 7'(mant)};
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Compare process: follows every handshake and checks the DUT each cycle.
    bit          busy = 0;
    bit          seen = 0;
    bit          hs_prev = 0;
    int          cnt = 0;
    int          exp_lat = 0;
    logic [15:0] exp_res = '0;
    logic [16:0] cur_lit = '0;
    logic [15:0] cur_a = '0;
    logic [15:0] cur_b = '0;
    logic [16:0] mres;
    logic [15:0] dut_res;

    always @(negedge clk) begin
        dut_res = {s_o, e_o, m_o};
        if (rst) begin
            check("rst_valid", valid_o, 0);
            check("rst_ready", ready_o, 1);
            check("rst_out", dut_res, 0);
            busy    = 0;
            seen    = 0;
            hs_prev = 0;
        end else begin
            if (hs_prev) begin
                check("ret_idle_ready", ready_o, 1);
                check("ret_idle_valid", valid_o, 0);
                hs_prev = 0;
                busy    = 0;
            end else if (busy) begin
                cnt++;
                check("busy_ready", ready_o, 0);
                if (valid_o) begin
                    if (!seen) begin
                        seen = 1;
                        check("latency", cnt, exp_lat);
                        if (cur_lit[16]) begin
                            check("literal", dut_res, cur_lit[15:0]);
                            check("model_pin", exp_res, cur_lit[15:0]);
                        end
                        $display("op %h / %h -> %h (model %h) latency %0d",
                                 cur_a, cur_b, dut_res, exp_res, cnt);
                    end
                    check("result", dut_res, exp_res);
                    if (ready_i) hs_prev = 1;
                end else if (cnt > exp_lat) begin
                    check("valid_timeout", cnt, exp_lat);
                    busy = 0;
                end
            end else begin
                check("idle_valid", valid_o, 0);
                check("idle_ready", ready_o, 1);
            end
            if (!busy && ready_o && valid_i) begin
                cur_a   = {sa_i, ea_i, ma_i};
                cur_b   = {sb_i, eb_i, mb_i};
                mres    = model(cur_a, cur_b);
                exp_res = mres[15:0];
                exp_lat = mres[16] ? 1 : ITER + 2;
                cur_lit = lit_exp;
                busy    = 1;
                seen    = 0;
                cnt     = 0;
            end
        end
    end

    function automatic logic [15:0] rand_op();
        int         cat;
        logic [7:0] e;
        logic [6:0] m;
        cat = $urandom_range(0, 11);
        m   = 7'($urandom);
        if (cat == 0) begin
            e = 8'h00;
        end else if (cat == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) m = 7'h00;
        end else if (cat < 8) begin
            e = 8'($urandom_range(90, 164));
        end else begin
            e = 8'($urandom_range(1, 254));
        end
        return {1'($urandom), e, m};
    endfunction

    task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
        {sa_i, ea_i, ma_i} = a;
        {sb_i, eb_i, mb_i} = b;
    endtask

    task automatic wait_accept();
        for (int n = 0; n <= 50; n++) begin
            if (n == 50) begin
                $display("FAIL accept_timeout: ready_o never rose, expected 1");
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
            if (ready_o) break;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        set_ops(16'($urandom), 16'($urandom));
    endtask

    // Caller is at posedge+1 with the divider idle.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [16:0] lit,
                         input int hold, input bit poke);
        set_ops(a, b);
        lit_exp = lit;
        ready_i = (hold == 0);
        valid_i = 1'b1;
        wait_accept();
        for (int n = 0; n <= 40; n++) begin
            if (n == 40) begin
                $display("FAIL valid_timeout: valid_o never rose, expected 1");
                $fatal(1, "valid timeout");
            end
            @(negedge clk);
            if (valid_o) break;
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (poke) begin
                    valid_i = 1'b1;
                    set_ops(rand_op(), rand_op());
                end
            end
            ready_i = 1'b1;
            valid_i = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        lit_exp = '0;
        set_ops(16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(16'h3F80, 16'h3F80, {1'b1, 16'h3F80}, 0, 0);
        do_op(16'h3F80, 16'h4040, {1'b1, 16'h3EAB}, 0, 0);
        do_op(16'hC0C0, 16'h4000, {1'b1, 16'hC040}, 0, 0);
        do_op(16'h3F80, 16'h0000, {1'b1, 16'h7F80}, 0, 0);
        do_op(16'h0000, 16'h0000, {1'b1, 16'h7FC0}, 0, 0);
        do_op(16'h7F00, 16'h3E80, {1'b1, 16'h7F80}, 0, 0);
        do_op(16'h0080, 16'h7F00, {1'b1, 16'h0000}, 0, 0);
        do_op(16'h4000, 16'h3F80, {1'b1, 16'h4000}, 20, 1);

        // Abort an operation mid-division, then check the next one is clean.
        set_ops(16'h3F80, 16'h4040);
        lit_exp = {1'b1, 16'h3EAB};
        valid_i = 1'b1;
        wait_accept();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(16'h3F80, 16'h4040, {1'b1, 16'h3EAB}, 0, 0);

        for (int i = 0; i < 300; i++) begin
            do_op(rand_op(), rand_op(), 17'h0, $urandom_range(0, 3), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
